// File: rtl/instr_tx_pkg.sv
// Shared definitions for the instruction UART (tx and rx directions):
// FSM encodings, widths and the default bit period.
package instr_tx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 217;
    localparam int unsigned INSTR_W          = 16;
    localparam int unsigned IDX_W            = 4;
    localparam int unsigned CNT_W            = 8;
    localparam int unsigned STATE_W          = 3;

    localparam logic [STATE_W-1:0] S_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] S_START_BIT  = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA_BITS  = 3'd2;
    localparam logic [STATE_W-1:0] S_STOP_BIT   = 3'd3;
    localparam logic [STATE_W-1:0] S_CLEANUP    = 3'd4;

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick_o is high while the
// count sits at its last value; clr_i forces the count back to zero.
module baud_tick
    import instr_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        // Registered tick lines up with the cycle the count equals LAST.
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/instr_tx.sv
// Instruction UART transmitter: sends a 16-bit word as two back-to-back
// 8N1 frames, low byte first, each byte LSB first.
module instr_tx
    import instr_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tx_dv,
    input  logic [INSTR_W-1:0] i_tx_instr,
    output logic               o_tx_serial,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               serial_q, serial_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   nxt_idx_c;
    logic               tick;
    logic               cnt_clr;

    assign nxt_idx_c = idx_q + IDX_W'(1);
    assign cnt_clr   = (state_q == S_IDLE) || (state_q == S_CLEANUP);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .tick_o(tick)
    );

    // Outputs are computed for the next state so they change with it.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (i_tx_dv) begin
                    state_d  = S_START_BIT;
                    data_d   = i_tx_instr;
                    idx_d    = '0;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START_BIT: begin
                if (tick) begin
                    state_d  = S_DATA_BITS;
                    serial_d = data_q[idx_q];
                end
            end
            S_DATA_BITS: begin
                if (tick) begin
                    if (idx_q[2:0] == 3'd7) begin
                        // Bit 7 continues to 8 for frame 1; bit 15 wraps to 0.
                        state_d  = S_STOP_BIT;
                        serial_d = 1'b1;
                        idx_d    = idx_q[3] ? IDX_W'(0) : IDX_W'(8);
                    end else begin
                        idx_d    = nxt_idx_c;
                        serial_d = data_q[nxt_idx_c];
                    end
                end
            end
            S_STOP_BIT: begin
                if (tick) begin
                    if (idx_q[3]) begin
                        state_d  = S_START_BIT;
                        serial_d = 1'b0;
                    end else begin
                        state_d  = S_CLEANUP;
                        serial_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            S_CLEANUP: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                idx_d    = '0;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_tx_serial = serial_q;
    assign o_tx_busy   = busy_q;
    assign o_tx_done   = done_q;

endmodule

// File: doc/instr_tx.md
INSTR_TX -- requirements
Module: instr_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 217, meaning clock cycles per UART bit (clock freq / baud); legal range 2..256.
REQ-002 The module SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port i_tx_dv  input  1  request strobe; o_tx_instr transfer is requested while high.
REQ-005 The module SHALL have port i_tx_instr  input  16  instruction word to transmit, sampled when a request is accepted.
REQ-006 The module SHALL have port o_tx_serial  output  1  UART line, idle high.
REQ-007 The module SHALL have port o_tx_busy  output  1  high while a transfer is in progress.
REQ-008 The module SHALL have port o_tx_done  output  1  one-cycle pulse when the full 16-bit transfer completes.

Function
REQ-009 The block SHALL transmit one 16-bit instruction as two back-to-back 8N1 UART frames: frame 0 = i_tx_instr[7:0], frame 1 = i_tx_instr[15:8], each LSB first.
REQ-010 Each frame SHALL be start bit (0), 8 data bits, stop bit (1); every bit SHALL be held on o_tx_serial for exactly CLKS_PER_BIT cycles.
REQ-011 Frame 1's start bit SHALL begin on the cycle immediately after frame 0's stop bit ends (no idle gap); total transfer = 20*CLKS_PER_BIT cycles.
REQ-012 FSM states SHALL be IDLE, TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT, CLEANUP; any unused encoding SHALL return to IDLE.
REQ-013 IDLE: o_tx_serial=1, o_tx_busy=0; if i_tx_dv=1 at a rising edge, the block SHALL latch i_tx_instr into an internal 16-bit register, clear bit index to 0, and enter TX_START_BIT.
REQ-014 o_tx_serial SHALL go low and o_tx_busy high on the first cycle after the accepting edge (latency 1 cycle).
REQ-015 TX_START_BIT -> TX_DATA_BITS after CLKS_PER_BIT cycles; TX_DATA_BITS drives latched bit [bit_idx], advancing bit_idx after each CLKS_PER_BIT cycles.
REQ-016 After bit_idx 7 or 15 completes, the FSM SHALL enter TX_STOP_BIT; bit_idx 7 -> 8 continues, bit_idx 15 -> 0 wraps.
REQ-017 TX_STOP_BIT end: if frame 0 just finished, go to TX_START_BIT; if frame 1 finished, go to CLEANUP.
REQ-018 CLEANUP SHALL last one cycle with o_tx_serial=1, o_tx_busy=1, o_tx_done=1, then enter IDLE.
REQ-019 The earliest next acceptance SHALL be on the IDLE cycle following CLEANUP; i_tx_dv held high continuously SHALL start back-to-back transfers with exactly one idle-high cycle between them.
REQ-020 i_tx_dv asserted while o_tx_busy=1 SHALL be ignored (not queued); changes on i_tx_instr after acceptance SHALL not affect the transfer in progress.
REQ-021 The bit-period counter SHALL be 8 bits wide, count 0..CLKS_PER_BIT-1, and reset to 0 at every bit boundary.

Reset
REQ-022 Asserting rst SHALL immediately (without a clock edge) force IDLE, o_tx_serial=1, o_tx_busy=0, o_tx_done=0, counter=0, bit_idx=0, data register=0.
REQ-023 Reset mid-transfer SHALL abort the transfer with no done pulse; the line SHALL return high within the reset-assert cycle.
REQ-024 After rst deassertion the block SHALL accept a request at the first rising edge with i_tx_dv=1.

Structure
REQ-025 FSM state encodings and the CLKS_PER_BIT default SHALL live in a shared package used by both instruction UART directions.
REQ-026 The bit-period counter SHALL be a sub-module named baud_tick (parameter CLKS_PER_BIT; output tick at count CLKS_PER_BIT-1; synchronous clear input).

Verification
REQ-027 CLKS_PER_BIT=4, send 0xA53C -> line: 0,0,0,1,1,1,1,0,0,1 (frame 0) then 0,1,0,1,0,0,1,0,1,1 (frame 1), each bit 4 cycles; o_tx_done pulses at cycle 81.
REQ-028 CLKS_PER_BIT=217, send 0x0000 then 0xFFFF -> each transfer 4340 cycles busy plus 1 cleanup; stop bits high; exactly one done pulse each.
REQ-029 Hold i_tx_dv high for 3 transfers with CLKS_PER_BIT=4 -> three transfers, one idle-high cycle between them, three done pulses.
REQ-030 Pulse i_tx_dv with 0x1234 during a transfer of 0x5678 -> only 0x5678 appears on the line; 0x1234 is not sent.
REQ-031 Assert rst asynchronously mid-frame 1 -> o_tx_serial=1, busy=0 before next edge, no done pulse; following request 0x00FF sends correctly.
REQ-032 Self-checking UART sampler decodes 1000 random words at CLKS_PER_BIT=217 -> all match, LSB-first byte order verified.
